// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the M-stage memory access unit: op encodings,
// exception codes, FSM states and small op-decoding helpers.
package mem_access_unit_pkg;

   typedef enum logic [3:0] {
      OP_NONE = 4'd0,
      OP_LB   = 4'd1,
      OP_LBU  = 4'd2,
      OP_LH   = 4'd3,
      OP_LHU  = 4'd4,
      OP_LW   = 4'd5,
      OP_LWU  = 4'd6,
      OP_LD   = 4'd7,
      OP_SB   = 4'd8,
      OP_SH   = 4'd9,
      OP_SW   = 4'd10,
      OP_SD   = 4'd11
   } mem_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_DBE  = 5'd7;

   // 64-bit-only ops are rejected like OP_NONE on a 32-bit datapath
   function automatic logic op_supported(input mem_op_e op, input logic dw64);
      case (op)
         OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW,
         OP_SB, OP_SH, OP_SW:          op_supported = 1'b1;
         OP_LWU, OP_LD, OP_SD:         op_supported = dw64;
         default:                      op_supported = 1'b0;
      endcase
   endfunction

   // log2 of the access size in bytes
   function automatic logic [1:0] op_size(input mem_op_e op);
      case (op)
         OP_LH, OP_LHU, OP_SH:         op_size = 2'd1;
         OP_LW, OP_LWU, OP_SW:         op_size = 2'd2;
         OP_LD, OP_SD:                 op_size = 2'd3;
         default:                      op_size = 2'd0;
      endcase
   endfunction

   function automatic logic op_is_store(input mem_op_e op);
      op_is_store = (op == OP_SB) || (op == OP_SH) || (op == OP_SW) || (op == OP_SD);
   endfunction

   function automatic logic op_is_signed(input mem_op_e op);
      op_is_signed = (op == OP_LB) || (op == OP_LH) || (op == OP_LW);
   endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Selects the addressed lane of a bus read word and sign- or zero-extends
// it to the full datapath width.
module load_extend #(
   parameter int DW = 32
) (
   input  logic [DW-1:0]            rdata,
   input  logic [$clog2(DW/8)-1:0]  lane,
   input  logic [1:0]               size,
   input  logic                     is_signed,
   output logic [DW-1:0]            ext_data
);

   logic [DW-1:0] shifted;
   logic [DW-1:0] mask;
   logic          sign;

   always_comb begin
      shifted = rdata >> {lane, 3'b000};
      mask    = '1;
      sign    = 1'b0;
      case (size)
         2'd0: begin
            mask = DW'(8'hFF);
            sign = shifted[7];
         end
         2'd1: begin
            mask = DW'(16'hFFFF);
            sign = shifted[15];
         end
         2'd2: begin
            mask = DW'(32'hFFFF_FFFF);
            sign = shifted[31];
         end
         default: ;
      endcase
      ext_data = (shifted & mask) | ((is_signed && sign) ? ~mask : '0);
   end

endmodule

// File: rtl/mem_access_unit.sv
// M-stage load/store unit: checks alignment, runs one bus transaction per
// request with a timeout, and returns an extended load result or exception.
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int DW      = 32,
   parameter int AW      = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   input  logic [3:0]        req_op,
   input  logic [AW-1:0]     req_addr,
   input  logic [DW-1:0]     req_wdata,
   input  logic              req_kill,
   output logic              stall,
   output logic              rsp_valid,
   output logic [DW-1:0]     rsp_rdata,
   output logic              exc_valid,
   output logic [4:0]        exc_code,
   output logic              bus_req,
   output logic              bus_we,
   output logic [AW-1:0]     bus_addr,
   output logic [DW/8-1:0]   bus_be,
   output logic [DW-1:0]     bus_wdata,
   input  logic              bus_ack,
   input  logic              bus_err,
   input  logic [DW-1:0]     bus_rdata
);

   localparam int   BEW    = DW / 8;
   localparam int   LANE_W = $clog2(BEW);
   localparam int   CW     = $clog2(TIMEOUT + 1);
   localparam logic IS_DW64 = (DW == 64);

   state_e            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   mem_op_e           op_q, op_d;
   logic              bus_we_q, bus_we_d;
   logic [AW-1:0]     bus_addr_q, bus_addr_d;
   logic [BEW-1:0]    bus_be_q, bus_be_d;
   logic [DW-1:0]     bus_wdata_q, bus_wdata_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DW-1:0]     rsp_rdata_q, rsp_rdata_d;
   logic              exc_valid_q, exc_valid_d;
   logic [4:0]        exc_code_q, exc_code_d;

   mem_op_e           req_op_e;
   logic              accept;
   logic [1:0]        req_size;
   logic              req_store;
   logic              misaligned;
   logic [LANE_W-1:0] req_lane;
   logic [BEW-1:0]    be_new;
   logic [DW-1:0]     wdata_new;
   logic [DW-1:0]     load_data;

   assign req_op_e  = mem_op_e'(req_op);
   assign req_size  = op_size(req_op_e);
   assign req_store = op_is_store(req_op_e);
   assign req_lane  = req_addr[LANE_W-1:0];
   assign accept    = (state_q == IDLE) && req_valid && !req_kill
                      && op_supported(req_op_e, IS_DW64);

   // Byte enables and lane-replicated store data for the incoming request
   always_comb begin
      misaligned = 1'b0;
      be_new     = '1;
      wdata_new  = req_wdata;
      case (req_size)
         2'd0: begin
            be_new    = BEW'(1) << req_lane;
            wdata_new = {(DW/8){req_wdata[7:0]}};
         end
         2'd1: begin
            misaligned = req_addr[0];
            be_new     = BEW'(3) << req_lane;
            wdata_new  = {(DW/16){req_wdata[15:0]}};
         end
         2'd2: begin
            misaligned = |req_addr[1:0];
            be_new     = BEW'(15) << req_lane;
            wdata_new  = {(DW/32){req_wdata[31:0]}};
         end
         default: begin
            misaligned = |req_addr[2:0];
         end
      endcase
   end

   load_extend #(
      .DW(DW)
   ) u_load_extend (
      .rdata     (bus_rdata),
      .lane      (bus_addr_q[LANE_W-1:0]),
      .size      (op_size(op_q)),
      .is_signed (op_is_signed(op_q)),
      .ext_data  (load_data)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      op_d        = op_q;
      bus_we_d    = bus_we_q;
      bus_addr_d  = bus_addr_q;
      bus_be_d    = bus_be_q;
      bus_wdata_d = bus_wdata_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      exc_valid_d = 1'b0;
      exc_code_d  = exc_code_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (misaligned) begin
                  state_d     = DONE;
                  exc_valid_d = 1'b1;
                  exc_code_d  = req_store ? EXC_ADES : EXC_ADEL;
               end else begin
                  state_d     = BUS;
                  cnt_d       = '0;
                  op_d        = req_op_e;
                  bus_we_d    = req_store;
                  bus_addr_d  = req_addr;
                  bus_be_d    = be_new;
                  bus_wdata_d = wdata_new;
               end
            end
         end
         BUS: begin
            // An error wins over a simultaneous ack
            if (bus_err) begin
               state_d     = DONE;
               exc_valid_d = 1'b1;
               exc_code_d  = EXC_DBE;
            end else if (bus_ack) begin
               state_d = DONE;
               if (!bus_we_q) begin
                  rsp_valid_d = 1'b1;
                  rsp_rdata_d = load_data;
               end
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               state_d     = DONE;
               exc_valid_d = 1'b1;
               exc_code_d  = EXC_DBE;
            end else if (cnt_q != CW'(TIMEOUT)) begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         op_q        <= OP_NONE;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_be_q    <= '0;
         bus_wdata_q <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         exc_valid_q <= 1'b0;
         exc_code_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         op_q        <= op_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_be_q    <= bus_be_d;
         bus_wdata_q <= bus_wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         exc_valid_q <= exc_valid_d;
         exc_code_q  <= exc_code_d;
      end
   end

   // Gated by reset so stall is low while reset is held
   assign stall     = reset && ((state_q == BUS) || accept);
   assign bus_req   = (state_q == BUS);
   assign bus_we    = bus_we_q;
   assign bus_addr  = bus_addr_q;
   assign bus_be    = bus_be_q;
   assign bus_wdata = bus_wdata_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign exc_valid = exc_valid_q;
   assign exc_code  = exc_code_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed corner cases plus random
// transactions on a 32-bit and a 64-bit instance, checked against a byte-level model.
module tb_mem_access_unit;
   import mem_access_unit_pkg::*;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        reqValid32, reqValid64, reqKill;
   logic [3:0]  reqOp;
   logic [31:0] reqAddr;
   logic [63:0] reqWdata;
   logic        busAck, busErr;
   logic [63:0] busRdata;
   logic        use64;

   logic        stall32, rspValid32, excValid32, busReq32, busWe32;
   logic [31:0] rspRdata32, busAddr32, busWdata32;
   logic [4:0]  excCode32;
   logic [3:0]  busBe32;

   logic        stall64, rspValid64, excValid64, busReq64, busWe64;
   logic [63:0] rspRdata64, busWdata64;
   logic [31:0] busAddr64;
   logic [4:0]  excCode64;
   logic [7:0]  busBe64;

   logic        obsStall, obsRsp, obsExc, obsReq, obsWe;
   logic [63:0] obsRdata, obsWdata, obsBe, obsAddr;
   logic [4:0]  obsCode;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_access_unit #(.DW(32), .AW(32), .TIMEOUT(TO)) dut32 (
      .clk(clk), .reset(reset), .req_valid(reqValid32), .req_op(reqOp),
      .req_addr(reqAddr), .req_wdata(reqWdata[31:0]), .req_kill(reqKill),
      .stall(stall32), .rsp_valid(rspValid32), .rsp_rdata(rspRdata32),
      .exc_valid(excValid32), .exc_code(excCode32), .bus_req(busReq32),
      .bus_we(busWe32), .bus_addr(busAddr32), .bus_be(busBe32),
      .bus_wdata(busWdata32), .bus_ack(busAck), .bus_err(busErr),
      .bus_rdata(busRdata[31:0])
   );

   mem_access_unit #(.DW(64), .AW(32), .TIMEOUT(TO)) dut64 (
      .clk(clk), .reset(reset), .req_valid(reqValid64), .req_op(reqOp),
      .req_addr(reqAddr), .req_wdata(reqWdata), .req_kill(reqKill),
      .stall(stall64), .rsp_valid(rspValid64), .rsp_rdata(rspRdata64),
      .exc_valid(excValid64), .exc_code(excCode64), .bus_req(busReq64),
      .bus_we(busWe64), .bus_addr(busAddr64), .bus_be(busBe64),
      .bus_wdata(busWdata64), .bus_ack(busAck), .bus_err(busErr),
      .bus_rdata(busRdata)
   );

   assign obsStall = use64 ? stall64    : stall32;
   assign obsRsp   = use64 ? rspValid64 : rspValid32;
   assign obsExc   = use64 ? excValid64 : excValid32;
   assign obsReq   = use64 ? busReq64   : busReq32;
   assign obsWe    = use64 ? busWe64    : busWe32;
   assign obsCode  = use64 ? excCode64  : excCode32;
   assign obsRdata = use64 ? rspRdata64 : {32'b0, rspRdata32};
   assign obsWdata = use64 ? busWdata64 : {32'b0, busWdata32};
   assign obsBe    = use64 ? {56'b0, busBe64} : {60'b0, busBe32};
   assign obsAddr  = use64 ? {32'b0, busAddr64} : {32'b0, busAddr32};

   // Reference model: access sizes in bytes and lane arithmetic
   function automatic int opBytes(input mem_op_e op);
      case (op)
         OP_LB, OP_LBU, OP_SB: return 1;
         OP_LH, OP_LHU, OP_SH: return 2;
         OP_LW, OP_LWU, OP_SW: return 4;
         OP_LD, OP_SD:         return 8;
         default:              return 0;
      endcase
   endfunction

   function automatic bit opStore(input mem_op_e op);
      return op == OP_SB || op == OP_SH || op == OP_SW || op == OP_SD;
   endfunction

   function automatic bit opSigned(input mem_op_e op);
      return op == OP_LB || op == OP_LH || op == OP_LW;
   endfunction

   function automatic logic [63:0] byteMask(input int n);
      if (n >= 8) return '1;
      return (64'd1 << (8 * n)) - 64'd1;
   endfunction

   function automatic logic [63:0] expBe(input int n, input logic [31:0] addr, input int dwB);
      return ((64'd1 << n) - 64'd1) << (addr % dwB);
   endfunction

   function automatic logic [63:0] expWdata(input int n, input logic [63:0] wdata, input int dwB);
      logic [63:0] r = '0;
      for (int i = 0; i < dwB / n; i++) r |= (wdata & byteMask(n)) << (8 * n * i);
      return r;
   endfunction

   function automatic logic [63:0] expLoad(input mem_op_e op, input logic [31:0] addr,
                                           input logic [63:0] rdata, input int dwB);
      int n = opBytes(op);
      logic [63:0] v = (rdata >> (8 * (addr % dwB))) & byteMask(n);
      if (opSigned(op) && v[8*n-1]) v |= ~byteMask(n);
      return v & byteMask(dwB);
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // mode: 0 ack, 1 err, 2 ack+err together, 3 no response (timeout)
   task automatic applyStimulus(input mem_op_e op, input logic [31:0] addr, input logic [63:0] wdata,
                                input logic kill, input int k, input int mode, input logic [63:0] rdata);
      int   n      = opBytes(op);
      int   dwB    = use64 ? 8 : 4;
      bit   accept = !kill && n != 0;
      bit   store  = opStore(op);
      bit   misal  = n > 1 && (addr % n) != 0;
      bit   expExc = mode != 0;
      bit   expRsp = !store && mode == 0;
      int   cycles = (mode == 3) ? TO - 1 : k;
      reqOp = op; reqAddr = addr; reqWdata = wdata; reqKill = kill;
      reqValid32 = !use64; reqValid64 = use64;
      busAck = 1'b0; busErr = 1'b0;
      #1 checkOutput("stall_on_accept", obsStall, accept);
      @(posedge clk); #1;
      reqValid32 = 1'b0; reqValid64 = 1'b0; reqKill = 1'b0;
      if (!accept) begin
         checkOutput("idle_no_bus_req", obsReq, 0);
         checkOutput("idle_no_stall", obsStall, 0);
         checkOutput("idle_no_exc", obsExc, 0);
      end else if (misal) begin
         checkOutput("misal_no_bus_req", obsReq, 0);
         checkOutput("misal_exc_valid", obsExc, 1);
         checkOutput("misal_exc_code", obsCode, store ? 5 : 4);
         checkOutput("misal_no_rsp", obsRsp, 0);
         checkOutput("misal_no_stall", obsStall, 0);
         @(posedge clk); #1;
         checkOutput("misal_exc_one_cycle", obsExc, 0);
      end else begin
         checkOutput("bus_req", obsReq, 1);
         checkOutput("bus_we", obsWe, store);
         checkOutput("bus_addr", obsAddr, {32'b0, addr});
         checkOutput("bus_be", obsBe, expBe(n, addr, dwB));
         if (store) checkOutput("bus_wdata", obsWdata, expWdata(n, wdata, dwB));
         checkOutput("bus_stall", obsStall, 1);
         for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            checkOutput("bus_req_held", obsReq, 1);
            checkOutput("bus_be_stable", obsBe, expBe(n, addr, dwB));
         end
         if (mode != 3) begin
            busRdata = rdata;
            busAck = (mode != 1);
            busErr = (mode != 0);
         end
         @(posedge clk); #1;
         busAck = 1'b0; busErr = 1'b0;
         checkOutput("done_bus_req_low", obsReq, 0);
         checkOutput("done_rsp_valid", obsRsp, expRsp);
         checkOutput("done_exc_valid", obsExc, expExc);
         if (expExc) checkOutput("done_exc_code", obsCode, 7);
         if (expRsp) checkOutput("load_rdata", obsRdata, expLoad(op, addr, rdata, dwB));
         @(posedge clk); #1;
         checkOutput("done_one_cycle_rsp", obsRsp, 0);
         checkOutput("done_one_cycle_exc", obsExc, 0);
      end
   endtask

   mem_op_e ops32[9]  = '{OP_NONE, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW};
   mem_op_e ops64[12] = '{OP_NONE, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWU, OP_LD,
                          OP_SB, OP_SH, OP_SW, OP_SD};

   initial begin
      mem_op_e     op;
      logic [31:0] addr;
      int          n, r, mode;
      reset = 1'b0; use64 = 1'b0;
      reqValid32 = 1'b0; reqValid64 = 1'b0; reqKill = 1'b0;
      reqOp = '0; reqAddr = '0; reqWdata = '0;
      busAck = 1'b0; busErr = 1'b0; busRdata = '0;
      $display("[TB] reset state");
      #12;
      checkOutput("rst_bus_req", obsReq, 0);
      checkOutput("rst_stall", obsStall, 0);
      checkOutput("rst_rsp_valid", obsRsp, 0);
      checkOutput("rst_exc_valid", obsExc, 0);
      checkOutput("rst_exc_code", obsCode, 0);
      checkOutput("rst_bus_be", obsBe, 0);
      checkOutput("rst_bus_addr", obsAddr, 0);
      checkOutput("rst_rdata", obsRdata, 0);
      use64 = 1'b1;
      #1 checkOutput("rst64_bus_wdata", obsWdata, 0);
      use64 = 1'b0;
      @(negedge clk); reset = 1'b1;
      @(negedge clk);

      $display("[TB] directed cases");
      applyStimulus(OP_SB,  32'h1003, 64'hAB, 1'b0, 0, 0, 64'h0);
      applyStimulus(OP_LB,  32'h2001, 64'h0, 1'b0, 2, 0, 64'h0000_8000);
      applyStimulus(OP_LBU, 32'h2001, 64'h0, 1'b0, 2, 0, 64'h0000_8000);
      applyStimulus(OP_LW,  32'h2002, 64'h0, 1'b0, 0, 0, 64'h0);
      applyStimulus(OP_SH,  32'h3001, 64'h0, 1'b0, 0, 0, 64'h0);
      applyStimulus(OP_LW,  32'h4000, 64'h0, 1'b0, 0, 3, 64'h0);
      applyStimulus(OP_LW,  32'h4004, 64'h0, 1'b0, 1, 2, 64'h1234_5678);
      applyStimulus(OP_LH,  32'h4006, 64'h0, 1'b0, 0, 1, 64'h0);
      applyStimulus(OP_SW,  32'h5000, 64'hDEAD_BEEF, 1'b1, 0, 0, 64'h0);
      applyStimulus(OP_LHU, 32'h6002, 64'h0, 1'b0, 1, 0, 64'hF00D_0000);
      applyStimulus(OP_SH,  32'h6002, 64'h5A_C3A5, 1'b0, 1, 0, 64'h0);

      $display("[TB] reset during bus cycle");
      reqOp = OP_LW; reqAddr = 32'h7000; reqValid32 = 1'b1;
      @(posedge clk); #1;
      reqValid32 = 1'b0;
      checkOutput("pre_reset_bus_req", obsReq, 1);
      @(posedge clk); #3;
      reset = 1'b0;
      #1;
      checkOutput("async_reset_bus_req", obsReq, 0);
      checkOutput("async_reset_stall", obsStall, 0);
      checkOutput("async_reset_exc", obsExc, 0);
      @(negedge clk); reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checkOutput("post_reset_rsp", obsRsp, 0);
         checkOutput("post_reset_exc", obsExc, 0);
         checkOutput("post_reset_bus_req", obsReq, 0);
      end

      $display("[TB] random 32-bit transactions");
      for (int t = 0; t < 30; t++) begin
         op = ops32[$urandom_range(0, 8)];
         n = opBytes(op);
         addr = $urandom;
         if (n > 0 && $urandom_range(0, 3) != 0) addr = addr & ~32'(n - 1);
         r = $urandom_range(0, 9);
         mode = (r < 7) ? 0 : ((r < 8) ? 1 : 2);
         applyStimulus(op, addr, {$urandom, $urandom}, $urandom_range(0, 7) == 0,
                       $urandom_range(0, 3), mode, {$urandom, $urandom});
      end

      $display("[TB] 64-bit datapath");
      use64 = 1'b1;
      applyStimulus(OP_LD,  32'h8, 64'h0, 1'b0, 0, 0, 64'h1122_3344_5566_7788);
      applyStimulus(OP_LWU, 32'hC, 64'h0, 1'b0, 1, 0, 64'h8765_4321_0000_0000);
      applyStimulus(OP_LW,  32'hC, 64'h0, 1'b0, 0, 0, 64'h8765_4321_0000_0000);
      applyStimulus(OP_SD,  32'h14, 64'h0, 1'b0, 0, 0, 64'h0);
      for (int t = 0; t < 20; t++) begin
         op = ops64[$urandom_range(0, 11)];
         n = opBytes(op);
         addr = $urandom;
         if (n > 0 && $urandom_range(0, 3) != 0) addr = addr & ~32'(n - 1);
         r = $urandom_range(0, 9);
         mode = (r < 8) ? 0 : 2;
         applyStimulus(op, addr, {$urandom, $urandom}, $urandom_range(0, 7) == 0,
                       $urandom_range(0, 3), mode, {$urandom, $urandom});
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter DW, default 32, data width (32 or 64).
REQ-002 SHALL have parameter AW, default 32, address width.
REQ-003 SHALL have parameter TIMEOUT, default 16, maximum bus wait cycles before bus error.
REQ-004 SHALL have port clk  in  1  single clock; all logic is rising-edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port req_valid  in  1  M-stage access request.
REQ-007 SHALL have port req_op  in  4  access op: NONE, LB, LBU, LH, LHU, LW, SB, SH, SW; LWU, LD, SD when DW=64.
REQ-008 SHALL have ports req_addr  in  AW and req_wdata  in  DW  access address and store data (LSBs valid).
REQ-009 SHALL have port req_kill  in  1  exception in flight; cancel request.
REQ-010 SHALL have port stall  out  1  hold upstream pipeline.
REQ-011 SHALL have ports rsp_valid  out  1 and rsp_rdata  out  DW  extended load result.
REQ-012 SHALL have ports exc_valid  out  1 and exc_code  out  5  exception: 4 AdEL, 5 AdES, 7 DBE.
REQ-013 SHALL have ports bus_req, bus_we  out  1; bus_addr  out  AW; bus_be  out  DW/8; bus_wdata  out  DW.
REQ-014 SHALL have ports bus_ack, bus_err  in  1 and bus_rdata  in  DW.

Function
REQ-015 SHALL implement FSM states IDLE, BUS, DONE.
REQ-016 In IDLE, req_valid=1, req_op!=NONE, req_kill=0 SHALL be accepted.
REQ-017 On acceptance, misaligned address (half: addr[0]; word: addr[1:0]; dword: addr[2:0]) SHALL go to DONE with exc_valid, code 4 (load) or 5 (store), and no bus cycle.
REQ-018 On aligned acceptance, op, addr, BE and lane-replicated wdata SHALL be registered and state SHALL go to BUS.
REQ-019 In BUS, bus_req SHALL be 1 and all bus_* outputs SHALL stay stable until bus_ack or bus_err.
REQ-020 bus_be SHALL be one lane per byte: byte = 1<<lane; half = 2'b11<<lane; word = 4'hF<<lane; dword = all ones.
REQ-021 bus_wdata SHALL replicate the byte, half or word across all lanes of that size.
REQ-022 On bus_ack, a load SHALL select its lane from bus_rdata, sign-extend (LB, LH, LW) or zero-extend (LBU, LHU, LWU) to DW, and register it into rsp_rdata.
REQ-023 bus_ack and bus_err in the same cycle SHALL be treated as bus_err.
REQ-024 bus_err, or TIMEOUT consecutive BUS cycles without ack, SHALL go to DONE with exc_valid=1, exc_code=7.
REQ-025 DONE SHALL last exactly one cycle with rsp_valid (successful load) or exc_valid pulsed, then return to IDLE.
REQ-026 Stores SHALL pulse neither rsp_valid nor exc_valid on success.
REQ-027 stall SHALL be combinational and high when: state==BUS, or state==IDLE and a request is being accepted.
REQ-028 Latency: accepted at cycle N, bus_req at N+1, ack at N+1+k (k>=0), rsp_valid at N+2+k.
REQ-029 req_kill SHALL be sampled only in IDLE; a bus cycle already issued SHALL complete and SHALL NOT be aborted.
REQ-030 Timeout counter SHALL be width clog2(TIMEOUT+1), clear on entering BUS, and saturate.

Reset
REQ-031 reset low SHALL asynchronously force state IDLE; counter 0; bus_req, bus_we, rsp_valid, exc_valid, stall 0; all data/addr/be outputs 0; exc_code 0.
REQ-032 reset asserted mid-BUS SHALL drop bus_req immediately with no response or exception.

Structure
REQ-033 Op encodings, exception codes and FSM state enum SHALL live in the shared macros/package file.
REQ-034 Load lane select/extension SHALL be a sub-module named load_extend, parametrised by DW.

Verification
REQ-035 SB addr 0x1003, wdata 0xAB, ack k=0 -> bus_be=4'b1000, bus_wdata=0xABABABAB, no rsp_valid.
REQ-036 LB addr 0x2001, bus_rdata 0x0000_8000, k=2 -> rsp_rdata=0xFFFF_FF80 at N+4; LBU same -> 0x0000_0080.
REQ-037 LW addr 0x2002 -> exc_valid at N+1, exc_code=4, bus_req never high; SH addr 0x3001 -> code 5.
REQ-038 LW with no ack, TIMEOUT=16 -> bus_req high 16 cycles, then exc_code=7; ack+err same cycle -> code 7.
REQ-039 req_kill=1 with SW -> no bus cycle, stall 0; reset low during BUS -> bus_req 0 asynchronously.
REQ-040 DW=64, LD addr 0x8, rdata 0x1122334455667788 -> rsp_rdata identical, bus_be=8'hFF.
